sync_fifo_mem: RTL and testbench
================================

Name: sync_fifo_mem

Overview:
Parametrised single-clock FIFO that wraps a storage array with its own pointer, occupancy and flag logic. It is the successor to the fixed 4-bit x 128 FIFO memory. It adds:
- configurable width and depth
- registered or first-word-fall-through (FWFT) read mode
- almost-full / almost-empty thresholds
- sticky overflow / underflow error flags
- synchronous flush

It is used as the same-domain buffer stage on either side of the CDC FIFO path.

Parameters:
DATA_W, 4, data word width in bits
ADDR_W, 7, address width; DEPTH = 2**ADDR_W (default 128 words)
AFULL_TH, 120, almost_full asserted when count >= AFULL_TH (1..DEPTH)
AEMPTY_TH, 4, almost_empty asserted when count <= AEMPTY_TH (0..DEPTH-1)
FWFT, 0, read mode: 0 = registered read, 1 = first-word-fall-through

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous reset, active-low; sampled on rising edge of clk
wr_en  input  1  write request
wdata  input  DATA_W  write data
rd_en  input  1  read/pop request
flush  input  1  synchronous clear of FIFO contents
clr_err  input  1  clears sticky error flags
rdata  output  DATA_W  read data
rvalid  output  1  rdata holds a freshly popped word (FWFT=0 only; tied 0 when FWFT=1)
full  output  1  count == DEPTH
empty  output  1  count == 0
almost_full  output  1  count >= AFULL_TH
almost_empty  output  1  count <= AEMPTY_TH
count  output  ADDR_W+1  current occupancy 0..DEPTH
overflow  output  1  sticky: write attempted while full
underflow  output  1  sticky: read attempted while empty

Behaviour:
- Reset (rst==0 at posedge):
  - wptr, rptr and count go to 0; rdata = 0; rvalid = 0; overflow = 0; underflow = 0.
  - Flags read empty=1, almost_empty=1, full=0, almost_full=0.
  - Storage array is not cleared.
  - Reset overrides all other inputs, including when it lands mid-burst.
- Acceptance: both decisions use the flags registered at the start of the cycle. There is no same-cycle full/empty bypass.
  - wr_acc = wr_en & ~full.
  - rd_acc = rd_en & ~empty.
- Write: on wr_acc, mem[wptr] <= wdata and wptr increments modulo DEPTH (wraps DEPTH-1 -> 0).
- Read with FWFT=0:
  - On rd_acc, rdata <= mem[rptr], rptr increments modulo DEPTH, and rvalid = 1 for exactly that following cycle.
  - Latency is 1 clk from rd_en to rdata/rvalid.
  - rdata holds its value when there is no pop.
- Read with FWFT=1:
  - rdata = mem[rptr] combinationally whenever empty==0, and 0 when empty==1.
  - On rd_acc, rptr increments and the next word appears after the edge.
  - A word written into an empty FIFO is visible on rdata the cycle after the write edge.
- Count update:
  - +1 on wr_acc only; -1 on rd_acc only; unchanged when both or neither occur.
  - Simultaneous rd/wr while full: the read is accepted and the write is rejected (overflow set); count becomes DEPTH-1.
  - Simultaneous rd/wr while empty: the write is accepted and the read is rejected (underflow set); count becomes 1.
- Flags:
  - All flags derive from the registered count and are valid from the cycle after the causing edge.
  - Thresholds use unsigned comparison at ADDR_W+1 bits.
- Errors:
  - overflow <= 1 on wr_en & full; underflow <= 1 on rd_en & empty.
  - Both flags hold until clr_err or reset.
  - If clr_err and a new error occur in the same cycle, the error wins (flag stays 1).
- Flush (priority below reset, above rd/wr):
  - wptr = rptr = count = 0; rvalid = 0; rdata holds (FWFT=0) or reads 0 (FWFT=1).
  - wr_en/rd_en in a flush cycle are ignored and raise no error flags.
  - Error flags are unaffected by flush.
- Pointer wrap: pointers are ADDR_W bits; full and empty are distinguished only by count, never by pointer equality.

Test Plan:
- Reset: hold rst=0 for 2 clk with wr_en=1, rd_en=1 -> count=0, empty=1, full=0, rdata=0, rvalid=0, overflow=0, underflow=0.
- Fill/drain (FWFT=0): write 0..127 mod 16 (128 words).
  - After the 120th write, almost_full=1; after the 128th, full=1 and count=128.
  - A 129th write sets overflow=1 and count stays 128.
  - Drain 128 pops -> rdata sequence 0,1,..,15,0,.. each 1 clk after rd_en; empty=1 after the last pop.
  - One more pop sets underflow=1.
- Wrap and simultaneous: preload 5 words, then run 300 cycles of wr_en=rd_en=1 with incrementing data -> count stays 5, order preserved across pointer wrap, almost_empty=0.
- Boundary simultaneous:
  - At full, wr_en=rd_en=1 -> count=127, overflow=1.
  - At empty, wr_en=rd_en=1 with wdata=0xA -> count=1, underflow=1, next pop returns 0xA.
- FWFT=1: write 0x3 into an empty FIFO -> rdata=0x3 on the next cycle with rd_en=0; rd_en=1 -> empty=1 and rdata=0 the cycle after.
- Flush/clr_err: with 10 words stored and overflow=1, assert flush together with wr_en=1 -> count=0, empty=1, overflow still 1. Then assert clr_err -> overflow=0.

Source files
------------

// File: rtl/sync_fifo_mem.sv
// Single-clock FIFO with width/depth parameters, registered or FWFT read,
// almost-full/empty thresholds, sticky error flags and synchronous flush.
module sync_fifo_mem #(
    parameter int DATA_W    = 4,
    parameter int ADDR_W    = 7,
    parameter int AFULL_TH  = 120,
    parameter int AEMPTY_TH = 4,
    parameter int FWFT      = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wdata,
    input  logic              rd_en,
    input  logic              flush,
    input  logic              clr_err,
    output logic [DATA_W-1:0] rdata,
    output logic              rvalid,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              underflow
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   AF_C    = (ADDR_W+1)'(AFULL_TH);
    localparam logic [ADDR_W:0]   AE_C    = (ADDR_W+1)'(AEMPTY_TH);
    localparam logic [ADDR_W:0]   C1      = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] P1      = ADDR_W'(1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wptr;
    logic [ADDR_W-1:0] rptr;
    logic [ADDR_W:0]   cnt;
    logic              wr_acc;
    logic              rd_acc;

    // Flags come only from the registered count; pointers may be equal
    // both when empty and when full.
    assign count        = cnt;
    assign empty        = (cnt == '0);
    assign full         = (cnt == DEPTH_C);
    assign almost_full  = (cnt >= AF_C);
    assign almost_empty = (cnt <= AE_C);

    assign wr_acc = wr_en & ~full;
    assign rd_acc = rd_en & ~empty;

    always_ff @(posedge clk) begin
        if (rst && !flush && wr_acc)
            mem[wptr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else if (flush) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (wr_acc)
                wptr <= wptr + P1;
            if (rd_acc)
                rptr <= rptr + P1;
            case ({wr_acc, rd_acc})
                2'b10:   cnt <= cnt + C1;
                2'b01:   cnt <= cnt - C1;
                default: cnt <= cnt;
            endcase
        end
    end

    // A new error in the same cycle as clr_err keeps the flag set.
    always_ff @(posedge clk) begin
        if (!rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (!flush && wr_en && full)
                overflow <= 1'b1;
            else if (clr_err)
                overflow <= 1'b0;
            if (!flush && rd_en && empty)
                underflow <= 1'b1;
            else if (clr_err)
                underflow <= 1'b0;
        end
    end

    if (FWFT == 0) begin : g_reg
        logic [DATA_W-1:0] rdata_q;
        logic              rvalid_q;

        always_ff @(posedge clk) begin
            if (!rst) begin
                rdata_q  <= '0;
                rvalid_q <= 1'b0;
            end else if (flush) begin
                rvalid_q <= 1'b0;
            end else begin
                rvalid_q <= rd_acc;
                if (rd_acc)
                    rdata_q <= mem[rptr];
            end
        end

        assign rdata  = rdata_q;
        assign rvalid = rvalid_q;
    end else begin : g_fwft
        assign rdata  = empty ? '0 : mem[rptr];
        assign rvalid = 1'b0;
    end

endmodule

// File: tb/tb_sync_fifo_mem.sv
// Directed bench for sync_fifo_mem: registered-read instance driven against
// a queue scoreboard, plus a small FWFT instance.
module tb_sync_fifo_mem;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en, rd_en, flush, clr_err;
    logic [3:0] wdata;
    logic [3:0] rdata;
    logic       rvalid, full, empty, almost_full, almost_empty;
    logic [7:0] count;
    logic       overflow, underflow;

    logic       f_wr, f_rd, f_fl, f_ce;
    logic [3:0] f_wd;
    logic [3:0] f_rdata;
    logic       f_rvalid, f_full, f_empty, f_af, f_ae;
    logic [7:0] f_count;
    logic       f_ovf, f_und;

    int         ncmp = 0;
    int         nerr = 0;
    logic [3:0] mq[$];
    logic [3:0] fq[$];
    int         mcount;
    logic       movf, mund;
    logic [3:0] mlast;

    always #5 clk = ~clk;

    sync_fifo_mem #(.FWFT(0)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wdata(wdata),
        .rd_en(rd_en), .flush(flush), .clr_err(clr_err),
        .rdata(rdata), .rvalid(rvalid), .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty),
        .count(count), .overflow(overflow), .underflow(underflow)
    );

    sync_fifo_mem #(.FWFT(1)) dut_f (
        .clk(clk), .rst(rst), .wr_en(f_wr), .wdata(f_wd),
        .rd_en(f_rd), .flush(f_fl), .clr_err(f_ce),
        .rdata(f_rdata), .rvalid(f_rvalid), .full(f_full), .empty(f_empty),
        .almost_full(f_af), .almost_empty(f_ae),
        .count(f_count), .overflow(f_ovf), .underflow(f_und)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        mcount = 0;
        movf   = 1'b0;
        mund   = 1'b0;
        mlast  = 4'h0;
    endtask

    // One clock of stimulus on the registered-read instance, then check.
    task automatic cyc(input logic w, input logic [3:0] d, input logic r,
                       input logic fl, input logic ce);
        logic       wa, ra;
        logic [3:0] e;
        wa = w && (mcount != 128) && !fl;
        ra = r && (mcount != 0) && !fl;
        e  = mlast;
        if (!fl && w && mcount == 128) movf = 1'b1;
        else if (ce) movf = 1'b0;
        if (!fl && r && mcount == 0) mund = 1'b1;
        else if (ce) mund = 1'b0;
        if (ra) e = mq.pop_front();
        if (wa) mq.push_back(d);
        if (fl) mq.delete();
        mcount = mq.size();
        wr_en = w; wdata = d; rd_en = r; flush = fl; clr_err = ce;
        @(posedge clk); #1;
        wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0; clr_err = 1'b0;
        mlast = e;
        chk("count", 32'(count), 32'(mcount));
        chk("rvalid", 32'(rvalid), 32'(ra));
        chk("rdata", 32'(rdata), 32'(e));
        chk("empty", 32'(empty), 32'(mcount == 0));
        chk("full", 32'(full), 32'(mcount == 128));
        chk("almost_full", 32'(almost_full), 32'(mcount >= 120));
        chk("almost_empty", 32'(almost_empty), 32'(mcount <= 4));
        chk("overflow", 32'(overflow), 32'(movf));
        chk("underflow", 32'(underflow), 32'(mund));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        wr_en = 1'b1; rd_en = 1'b1; wdata = 4'h5;
        flush = 1'b0; clr_err = 1'b0;
        f_wr = 1'b1; f_rd = 1'b1; f_wd = 4'h5; f_fl = 1'b0; f_ce = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        wr_en = 1'b0; rd_en = 1'b0;
        f_wr = 1'b0; f_rd = 1'b0;
        model_reset();
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_rdata", 32'(rdata), 32'd0);
        chk("rst_rvalid", 32'(rvalid), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_und", 32'(underflow), 32'd0);
        chk("rst_aempty", 32'(almost_empty), 32'd1);
        chk("rst_f_empty", 32'(f_empty), 32'd1);
        chk("rst_f_rdata", 32'(f_rdata), 32'd0);

        // Fill to full, one extra write, drain, one extra pop
        for (int i = 0; i < 128; i++) cyc(1'b1, 4'(i), 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 4'hF, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 128; i++) cyc(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 4'h0, 1'b0, 1'b0, 1'b1);

        // Steady simultaneous traffic across pointer wrap
        for (int i = 0; i < 5; i++) cyc(1'b1, 4'(i + 9), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 300; i++) cyc(1'b1, 4'(i), 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) cyc(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);

        // Simultaneous access at the full and empty boundaries
        for (int i = 0; i < 128; i++) cyc(1'b1, 4'(i * 3), 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 4'h7, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 127; i++) cyc(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 4'hA, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);

        // Flush with errors pending, then clear errors
        for (int i = 0; i < 10; i++) cyc(1'b1, 4'(i + 2), 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 4'h5, 1'b1, 1'b1, 1'b0);
        cyc(1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 4'hC, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);

        // Reset landing in the middle of a write burst
        for (int i = 0; i < 3; i++) cyc(1'b1, 4'(i), 1'b0, 1'b0, 1'b0);
        wr_en = 1'b1; wdata = 4'h6; rst = 1'b0;
        @(posedge clk); #1;
        wr_en = 1'b0; rst = 1'b1;
        model_reset();
        chk("midrst_count", 32'(count), 32'd0);
        chk("midrst_rdata", 32'(rdata), 32'd0);
        chk("midrst_empty", 32'(empty), 32'd1);
        cyc(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);

        // FWFT instance
        f_wr = 1'b1; f_wd = 4'h3; fq.push_back(4'h3);
        @(posedge clk); #1;
        f_wr = 1'b0;
        chk("fwft_vis", 32'(f_rdata), 32'(fq[0]));
        chk("fwft_nempty", 32'(f_empty), 32'd0);
        @(posedge clk); #1;
        chk("fwft_hold", 32'(f_rdata), 32'(fq[0]));
        chk("fwft_count", 32'(f_count), 32'd1);
        f_rd = 1'b1; void'(fq.pop_front());
        @(posedge clk); #1;
        f_rd = 1'b0;
        chk("fwft_empty", 32'(f_empty), 32'd1);
        chk("fwft_zero", 32'(f_rdata), 32'd0);
        chk("fwft_rvalid", 32'(f_rvalid), 32'd0);
        f_wr = 1'b1; f_wd = 4'h7; fq.push_back(4'h7);
        @(posedge clk); #1;
        f_wd = 4'h9; fq.push_back(4'h9);
        @(posedge clk); #1;
        f_wr = 1'b0;
        chk("fwft_first", 32'(f_rdata), 32'(fq[0]));
        f_rd = 1'b1; void'(fq.pop_front());
        @(posedge clk); #1;
        f_rd = 1'b0;
        chk("fwft_next", 32'(f_rdata), 32'(fq[0]));
        chk("fwft_cnt1", 32'(f_count), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
